// File: rtl/calc_sequencer_if.sv
// Bus bundle between the calc_sequencer and its environment: job command,
// operand stream, datapath drive/return and the result port.
interface calc_sequencer_if #(
   parameter int unsigned LEN_W = 8,
   parameter int unsigned ACC_W = 32
);
   // job command
   logic             cmd_valid;
   logic             cmd_ready;
   logic [LEN_W-1:0] cmd_len;
   // operand stream
   logic             op_valid;
   logic             op_ready;
   logic [127:0]     op_a;
   logic [127:0]     op_b;
   // datapath drive and return
   logic [127:0]     dp_a;
   logic [127:0]     dp_b;
   logic             dp_load;
   logic [24:0]      dp_result;
   // result port
   logic             res_valid;
   logic             res_ready;
   logic [ACC_W-1:0] res_data;
   logic [15:0]      res_cycles;

   // environment side: issues jobs, supplies operands, returns datapath sums
   modport master (
      output cmd_valid, cmd_len, op_valid, op_a, op_b, dp_result, res_ready,
      input  cmd_ready, op_ready, dp_a, dp_b, dp_load, res_valid, res_data, res_cycles
   );

   // sequencer side
   modport slave (
      input  cmd_valid, cmd_len, op_valid, op_a, op_b, dp_result, res_ready,
      output cmd_ready, op_ready, dp_a, dp_b, dp_load, res_valid, res_data, res_cycles
   );
endinterface

// File: rtl/calc_sequencer.sv
// Job sequencer for the nibble-sliced calculation datapath: streams N operand
// pairs into the datapath, tags each load through the datapath latency,
// accumulates the tagged 25-bit sums and returns total plus cycle count.
module calc_sequencer #(
   parameter int unsigned PIPE_LAT = 3,
   parameter int unsigned MAX_LEN  = 16,
   parameter int unsigned LEN_W    = 8,
   parameter int unsigned ACC_W    = 32
) (
   input logic              clk,
   input logic              rst,
   calc_sequencer_if.slave  bus
);

   localparam int unsigned      CNT_W     = $clog2(MAX_LEN + 1);
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   len_q, issued, retired;
   logic [CNT_W-1:0]   len_clamp, retired_nx;
   logic [PIPE_LAT-1:0] tag, tag_shift;
   logic [PIPE_LAT:0]  tag_chain;
   logic               tag_out;
   logic [ACC_W-1:0]   acc, acc_nx;
   logic [15:0]        cyc_cnt, cyc_nx;
   logic               cmd_fire, op_fire, done_entry;

   assign cmd_fire  = (state == IDLE) && bus.cmd_valid;
   assign op_fire   = (state == FEED) && bus.op_valid;
   assign len_clamp = (bus.cmd_len > MAX_LEN_L) ? CNT_W'(MAX_LEN) : CNT_W'(bus.cmd_len);

   // The tag chain treats dp_load as stage 0; the oldest stage lines up with
   // the cycle in which the matching dp_result is valid.
   assign tag_chain  = {tag, bus.dp_load};
   assign tag_shift  = tag_chain[PIPE_LAT-1:0];
   assign tag_out    = tag[PIPE_LAT-1];
   assign acc_nx     = tag_out ? acc + ACC_W'(bus.dp_result) : acc;
   assign retired_nx = retired + CNT_W'(tag_out);
   assign cyc_nx     = (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;
   assign done_entry = (state != DONE) && (state_nx == DONE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state and handshake-ready decode
   always_comb begin
      state_nx      = state;
      bus.cmd_ready = 1'b0;
      bus.op_ready  = 1'b0;
      unique case (state)
         IDLE: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) state_nx = (len_clamp == '0) ? DONE : FEED;
         end
         FEED: begin
            bus.op_ready = 1'b1;
            if (bus.op_valid && (issued + CNT_W'(1) == len_q)) state_nx = DRAIN;
         end
         DRAIN: begin
            // DONE is entered on the same edge that retires the final sum,
            // so the last accumulation lands directly in res_data.
            if ((retired_nx == len_q) && (tag_shift == '0)) state_nx = DONE;
         end
         DONE: begin
            if (bus.res_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Job bookkeeping: length, issue/retire counts, tag chain, accumulator, cycle count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q   <= '0;
         issued  <= '0;
         retired <= '0;
         tag     <= '0;
         acc     <= '0;
         cyc_cnt <= '0;
      end else begin
         tag <= tag_shift;
         if (cmd_fire) begin
            len_q   <= len_clamp;
            issued  <= '0;
            retired <= '0;
            acc     <= '0;
            cyc_cnt <= '0;
         end else begin
            if (op_fire) issued <= issued + CNT_W'(1);
            retired <= retired_nx;
            acc     <= acc_nx;
            if ((state == FEED) || (state == DRAIN)) cyc_cnt <= cyc_nx;
         end
      end
   end

   // Registered operand drive into the datapath; operands hold through bubbles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.dp_a    <= '0;
         bus.dp_b    <= '0;
         bus.dp_load <= 1'b0;
      end else begin
         bus.dp_load <= op_fire;
         if (op_fire) begin
            bus.dp_a <= bus.op_a;
            bus.dp_b <= bus.op_b;
         end
      end
   end

   // Result capture on DONE entry, held until the result handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.res_valid  <= 1'b0;
         bus.res_data   <= '0;
         bus.res_cycles <= '0;
      end else if (done_entry) begin
         bus.res_valid  <= 1'b1;
         bus.res_data   <= (state == IDLE) ? '0 : acc_nx;
         bus.res_cycles <= (state == IDLE) ? '0 : cyc_nx;
      end else if ((state == DONE) && bus.res_ready) begin
         bus.res_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: table of jobs with a datapath
// model, result scoreboard, plus hand-written abort and DONE-hold sequences.
module tb_calc_sequencer;

   localparam int unsigned PIPE_LAT = 3;
   localparam int unsigned MAX_LEN  = 16;
   localparam int unsigned LEN_W    = 8;
   localparam int unsigned ACC_W    = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   calc_sequencer_if #(.LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();

   calc_sequencer #(
      .PIPE_LAT(PIPE_LAT),
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W),
      .ACC_W   (ACC_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;
   int unsigned cyc    = 0;

   // free-running cycle index
   always @(posedge clk) cyc <= cyc + 1;

   // Datapath model: elementwise row/column dot product, PIPE_LAT latency;
   // untagged cycles return random garbage.
   logic [PIPE_LAT-1:0] mv   = '0;
   logic [24:0]         md [PIPE_LAT];
   logic [24:0]         garb = '0;

   function automatic logic [24:0] dot(input logic [127:0] a, input logic [127:0] b);
      logic [47:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) s += 48'(a[16*i +: 16]) * 48'(b[16*i +: 16]);
      return s[24:0];
   endfunction

   // datapath model pipeline
   always @(posedge clk) begin
      garb  <= 25'($urandom);
      mv    <= {mv[PIPE_LAT-2:0], bus.dp_load};
      md[0] <= dot(bus.dp_a, bus.dp_b);
      for (int i = 1; i < PIPE_LAT; i++) md[i] <= md[i-1];
   end
   assign bus.dp_result = mv[PIPE_LAT-1] ? md[PIPE_LAT-1] : garb;

   // Monitors: accepted beats, dp_load count/run length, res_valid rise cycle
   int unsigned beats_total = 0, loads_total = 0, run = 0, last_run = 0, rv_rise = 0;
   logic        rv_prev = 1'b0;
   always @(negedge clk) begin
      if (bus.op_valid && bus.op_ready) beats_total <= beats_total + 1;
      if (bus.dp_load) begin
         loads_total <= loads_total + 1;
         run         <= run + 1;
      end else begin
         if (run != 0) last_run <= run;
         run <= 0;
      end
      if (bus.res_valid && !rv_prev) rv_rise <= cyc;
      rv_prev <= bus.res_valid;
   end

   typedef struct {
      int unsigned      len;
      int unsigned      kind;
      int unsigned      gap;
      int unsigned      hold;
      logic [ACC_W-1:0] exp_data;
   } vec_t;

   typedef struct {
      logic [ACC_W-1:0] data;
      logic [15:0]      cycles;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic make_ops(input int unsigned kind, input int unsigned idx,
                           output logic [127:0] a, output logic [127:0] b);
      a = '0;
      b = '0;
      case (kind)
         0: for (int r = 0; r < 8; r++) begin
               a[16*r +: 16] = 16'd1;
               b[16*r +: 16] = 16'd1;
            end
         1: begin a[15:0] = 16'(idx + 1); b[15:0] = 16'd1; end
         2: begin
               a[15:0]  = 16'h01FF; b[15:0]  = 16'hFFFF;
               a[31:16] = 16'd2;    b[31:16] = 16'h80FF;
            end
         default: begin a[15:0] = 16'(idx + 3); b[15:0] = 16'd1; end
      endcase
   endtask

   task automatic run_job(input vec_t v);
      int unsigned    L, last_hs, exp_lat, exp_cyc, b0, l0, acc_cyc, waited;
      logic [127:0]   a, b;
      exp_t           e;
      L       = (v.len > MAX_LEN) ? MAX_LEN : v.len;
      last_hs = (L == 0) ? 0 : 1 + (L - 1) * (v.gap + 1);
      exp_lat = (L == 0) ? 1 : last_hs + PIPE_LAT + 2;
      exp_cyc = (L == 0) ? 0 : last_hs + PIPE_LAT + 1;
      e.data   = v.exp_data;
      e.cycles = 16'(exp_cyc);
      sb.push_back(e);
      b0 = beats_total;
      l0 = loads_total;

      chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = LEN_W'(v.len);
      @(posedge clk); #1;
      acc_cyc       = cyc;
      bus.cmd_valid = 1'b0;
      chk("cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);

      for (int unsigned i = 0; i < L; i++) begin
         make_ops(v.kind, i, a, b);
         bus.op_a     = a;
         bus.op_b     = b;
         bus.op_valid = 1'b1;
         chk("op_ready_feed", 64'(bus.op_ready), 64'd1);
         @(posedge clk); #1;
         bus.op_valid = 1'b0;
         if (i + 1 < L)
            for (int unsigned g = 0; g < v.gap; g++) begin @(posedge clk); #1; end
      end

      // extra offered beats that must not be accepted
      bus.op_a     = 128'h1234;
      bus.op_b     = 128'h1;
      bus.op_valid = 1'b1;
      if (L > 0) chk("op_ready_after_last", 64'(bus.op_ready), 64'd0);
      for (int k = 0; k < 2; k++) begin @(posedge clk); #1; end
      bus.op_valid = 1'b0;

      waited = 0;
      while (!bus.res_valid && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("res_valid_wait", 64'(bus.res_valid), 64'd1);
      if (!bus.res_valid) begin
         sb.delete(sb.size() - 1);
         return;
      end
      @(negedge clk); #1;
      chk("latency", 64'(rv_rise - acc_cyc + 1), 64'(exp_lat));
      chk("beats_accepted", 64'(beats_total - b0), 64'(L));
      chk("dp_load_count", 64'(loads_total - l0), 64'(L));
      if (L > 0) chk("dp_load_run", 64'(last_run), (v.gap == 0) ? 64'(L) : 64'd1);

      for (int unsigned h = 0; h < v.hold; h++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_len   = 8'd3;
         chk("hold_res_valid", 64'(bus.res_valid), 64'd1);
         chk("hold_res_data", 64'(bus.res_data), 64'(sb[0].data));
         chk("hold_cmd_ready", 64'(bus.cmd_ready), 64'd0);
         @(posedge clk); #1;
      end
      bus.cmd_valid = 1'b0;

      if (sb.size() == 0) begin
         chk("scoreboard_empty", 64'd1, 64'd0);
         return;
      end
      e = sb.pop_front();
      chk("res_data", 64'(bus.res_data), 64'(e.data));
      chk("res_cycles", 64'(bus.res_cycles), 64'(e.cycles));
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      chk("res_valid_cleared", 64'(bus.res_valid), 64'd0);
      chk("cmd_ready_back", 64'(bus.cmd_ready), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_dp_a"},       64'(bus.dp_a == '0), 64'd1);
      chk({tag, "_dp_b"},       64'(bus.dp_b == '0), 64'd1);
      chk({tag, "_dp_load"},    64'(bus.dp_load), 64'd0);
      chk({tag, "_res_valid"},  64'(bus.res_valid), 64'd0);
      chk({tag, "_res_data"},   64'(bus.res_data), 64'd0);
      chk({tag, "_res_cycles"}, 64'(bus.res_cycles), 64'd0);
      chk({tag, "_op_ready"},   64'(bus.op_ready), 64'd0);
      chk({tag, "_cmd_ready"},  64'(bus.cmd_ready), 64'd1);
   endtask

   // watchdog
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // main stimulus
   initial begin
      logic [127:0] a, b;
      vec_t         post;

      vecs[0] = '{len: 1,   kind: 0, gap: 0, hold: 0,  exp_data: 32'd8};
      vecs[1] = '{len: 16,  kind: 1, gap: 0, hold: 0,  exp_data: 32'd136};
      vecs[2] = '{len: 4,   kind: 2, gap: 1, hold: 0,  exp_data: 32'h07FF_FFFC};
      vecs[3] = '{len: 0,   kind: 1, gap: 0, hold: 0,  exp_data: 32'd0};
      vecs[4] = '{len: 200, kind: 1, gap: 0, hold: 0,  exp_data: 32'd136};
      vecs[5] = '{len: 1,   kind: 0, gap: 0, hold: 10, exp_data: 32'd8};
      post    = '{len: 2,   kind: 3, gap: 0, hold: 0,  exp_data: 32'd7};

      bus.cmd_valid = 1'b0;
      bus.cmd_len   = '0;
      bus.op_valid  = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.res_ready = 1'b0;

      for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
      check_reset_outputs("reset");
      #1 rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) run_job(vecs[i]);

      // asynchronous reset in the middle of FEED, after five accepted beats
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = 8'd8;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      for (int unsigned i = 0; i < 5; i++) begin
         make_ops(1, i + 100, a, b);
         bus.op_a     = a;
         bus.op_b     = b;
         bus.op_valid = 1'b1;
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("abort");
      bus.op_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;

      run_job(post);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Job sequencer for the 8x8 nibble-sliced `calculation` datapath. It accepts a dot-product job of N operand pairs and streams them into the datapath one per accepted beat. It tracks in-flight operands through the datapath pipeline, accumulates the 25-bit partial results into a wide sum, and returns the total with a cycle count over a valid/ready result port. It sits between the operand buffers and the `calculation` instance and owns all sequencing of that datapath.

## Interface
Parameters:
- PIPE_LAT, 3: cycles from the `dp_load`-high cycle to the cycle in which the matching `dp_result` is valid; legal range 1..8.
- MAX_LEN, 16: largest pair count per job; larger `cmd_len` values are clamped to MAX_LEN.
- LEN_W, 8: width of `cmd_len`.
- ACC_W, 32: accumulator width; must be at least 25 + clog2(MAX_LEN).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  high in IDLE.
- cmd_len  in  LEN_W  number of operand pairs in the job.
- op_valid  in  1  operand pair present.
- op_ready  out  1  high in FEED.
- op_a  in  128  A operand, 8 rows x 16 bits.
- op_b  in  128  B operand, 8 columns x 16 bits.
- dp_a  out  128  registered A to datapath.
- dp_b  out  128  registered B to datapath.
- dp_load  out  1  marks the cycle `dp_a`/`dp_b` carry a new pair.
- dp_result  in  25  datapath sum output.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_data  out  ACC_W  accumulated sum.
- res_cycles  out  16  cycles from cmd accept to DONE entry; saturates at 0xFFFF.

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`:
    - latch len = min(`cmd_len`, MAX_LEN); clear acc, issued, retired, cycle counter.
    - If len==0, go to DONE; otherwise go to FEED.
- **FEED**
  - `op_ready`=1.
  - Each `op_valid`&`op_ready` edge:
    - `dp_a`<=`op_a`, `dp_b`<=`op_b`; `dp_load`<=1 for the next cycle only; issued++.
  - When the handshake makes issued==len, go to DRAIN; `op_ready` is 0 from the next cycle.
  - Bubbles (`op_valid`=0) are allowed: `dp_load`=0 and `dp_a`/`dp_b` hold.
- **Tag pipeline**
  - PIPE_LAT-bit shift register; bit 0 = `dp_load`, shifted every cycle.
  - When the output bit is 1: acc += zero-extended `dp_result`; retired++.
  - Untagged `dp_result` values are never accumulated.
- **DRAIN**
  - Accumulation continues.
  - When retired==len and the tag register is empty, go to DONE.
- **DONE**
  - `res_valid`=1; `res_data`=acc; `res_cycles` held.
  - On `res_ready`, go to IDLE.
  - `cmd_ready`=0 until IDLE.
- Arithmetic:
  - acc is unsigned, modulo 2^ACC_W.
  - The parameter constraint guarantees no wrap for legal jobs.
- Cycle counter:
  - increments every cycle in FEED and DRAIN; stops on DONE entry; saturates at 0xFFFF.
- Reset (async, any state):
  - state=IDLE; acc, counters, tag register cleared.
  - `dp_a`=`dp_b`=0, `dp_load`=0, `res_valid`=0, `res_data`=0, `res_cycles`=0, `op_ready`=0.
  - `cmd_ready`=1 (state decode). `cmd_valid` is not sampled while `rst`=1.
  - An aborted job produces no result; in-flight datapath outputs after release are ignored because the tags are cleared.

## Timing
- Cmd handshake at edge t: FEED from t, so `op_ready`=1 in cycle t+1.
- Op handshake at edge t: `dp_load`=1 in cycle t+1; matching result is accumulated at edge t+1+PIPE_LAT.
- Back-to-back: one pair per cycle, no bubbles inserted by the block.
- Minimum job latency with continuous `op_valid`, cmd accept to `res_valid`: len + PIPE_LAT + 2 cycles.
- len==0: `res_valid` in the cycle after cmd accept; `res_data`=0; `res_cycles`=0.
- `res_valid` held stable with constant `res_data` until `res_ready`; a new cmd is accepted no earlier than the cycle after the result handshake.
- Outputs `dp_a`, `dp_b`, `dp_load`, `res_*` are registered; `cmd_ready`/`op_ready` decode from state.

## Test plan
- Reset, then a len=1 job: `op_a`=all rows 0x0001, `op_b`=all columns 0x0001, datapath model returns 8 -> `res_data`=8, `res_valid` exactly 1+PIPE_LAT+2 cycles after cmd accept, `res_cycles`=PIPE_LAT+2.
- len=16 back-to-back with model result k (k=1..16) per pair -> `res_data`=136; `dp_load` high for 16 consecutive cycles; `op_ready` low after the 16th beat.
- len=4 with `op_valid` toggling every other cycle, results 0x1FFFFFF each -> `res_data`=0x7FFFFFC; untagged `dp_result` garbage in bubble cycles not accumulated.
- `cmd_len`=0 -> `res_valid` next cycle, `res_data`=0; `cmd_len`=200 -> clamped, exactly 16 operand beats accepted.
- Assert `rst` asynchronously mid-FEED after 5 beats -> all outputs 0 immediately, `cmd_ready`=1. Next len=2 job with results 3 and 4 -> 7, with no contribution from the aborted job.
- Hold `res_ready`=0 for 10 cycles in DONE -> `res_valid`/`res_data` stable, `cmd_valid` not accepted; release -> IDLE next cycle.
